// File: rtl/button_event_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : button_event_arbiter
// Brief    : Debounced push-button edge events, one pending slot per button,
//            shared round-robin output with valid/ready handshake.
// Revision : 1.0
// ============================================================================
module button_event_arbiter #(
    parameter int N               = 4,
    parameter int DEBOUNCE_CYCLES = 16,
    localparam int IDW            = $clog2((N > 2) ? N : 2)
) (
    input  logic           sysclk,
    input  logic           rst,
    input  logic [N-1:0]   btn,
    input  logic           evt_ready,
    output logic           evt_valid,
    output logic [IDW-1:0] evt_id,
    output logic           dropped,
    output logic [N-1:0]   pending
);

    localparam int                 c_CNT_W   = $clog2(DEBOUNCE_CYCLES);
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [IDW-1:0]     c_LAST_ID = IDW'(N - 1);

    logic [N-1:0]         r_sync1;
    logic [N-1:0]         r_sync2;
    logic [N-1:0]         r_stable;
    logic [N-1:0]         r_stable_d;
    logic [c_CNT_W-1:0]   r_cnt [N];
    logic [N-1:0]         r_pending;
    logic                 r_dropped;
    logic                 r_evt_valid;
    logic [IDW-1:0]       r_evt_id;
    logic [IDW-1:0]       r_ptr;

    logic [N-1:0]         w_rise;
    logic                 w_load;
    logic                 w_found;
    logic                 w_grant;
    logic [IDW-1:0]       w_gnt_idx;
    logic [N-1:0]         w_gnt_vec;
    logic [N-1:0]         w_pending_nxt;
    logic                 w_dropped_nxt;

    // Synchroniser and debounce: the stable level only follows the synchronised
    // input after it has disagreed for DEBOUNCE_CYCLES consecutive cycles.
    always_ff @(posedge sysclk) begin
        if (rst) begin
            r_sync1    <= '0;
            r_sync2    <= '0;
            r_stable   <= '0;
            r_stable_d <= '0;
            for (int i = 0; i < N; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_sync1    <= btn;
            r_sync2    <= r_sync1;
            r_stable_d <= r_stable;
            for (int i = 0; i < N; i++) begin
                if (r_sync2[i] == r_stable[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] == c_CNT_MAX) begin
                    r_stable[i] <= r_sync2[i];
                    r_cnt[i]    <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign w_rise = r_stable & ~r_stable_d;
    assign w_load = ~r_evt_valid | evt_ready;

    // Round-robin search: walk offsets downward so the nearest pending channel
    // at or above the pointer is the last (winning) assignment.
    always_comb begin
        w_found   = 1'b0;
        w_gnt_idx = '0;
        for (int k = N - 1; k >= 0; k--) begin
            int j;
            j = int'(r_ptr) + k;
            if (j >= N) begin
                j = j - N;
            end
            if (r_pending[j]) begin
                w_found   = 1'b1;
                w_gnt_idx = IDW'(j);
            end
        end
    end

    assign w_grant   = w_load & w_found;
    assign w_gnt_vec = w_grant ? (N'(1) << w_gnt_idx) : '0;

    // A new rise on the channel being granted re-arms it instead of dropping.
    assign w_pending_nxt = (r_pending & ~w_gnt_vec) | w_rise;
    assign w_dropped_nxt = |(w_rise & r_pending & ~w_gnt_vec);

    always_ff @(posedge sysclk) begin
        if (rst) begin
            r_pending   <= '0;
            r_dropped   <= 1'b0;
            r_evt_valid <= 1'b0;
            r_evt_id    <= '0;
            r_ptr       <= '0;
        end else begin
            r_pending <= w_pending_nxt;
            r_dropped <= w_dropped_nxt;
            if (w_load) begin
                r_evt_valid <= w_found;
                if (w_found) begin
                    r_evt_id <= w_gnt_idx;
                    r_ptr    <= (w_gnt_idx == c_LAST_ID) ? '0 : w_gnt_idx + 1'b1;
                end
            end
        end
    end

    assign evt_valid = r_evt_valid;
    assign evt_id    = r_evt_id;
    assign dropped   = r_dropped;
    assign pending   = r_pending;

endmodule
`default_nettype wire

// File: tb/tb_button_event_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_button_event_arbiter
// Brief    : Directed self-checking bench for button_event_arbiter (N=4, D=16).
// Revision : 1.0
// ============================================================================
module tb_button_event_arbiter;

    logic       sysclk;
    logic       rst;
    logic [3:0] btn;
    logic       evt_ready;
    logic       evt_valid;
    logic [1:0] evt_id;
    logic       dropped;
    logic [3:0] pending;

    int n_total  = 0;
    int n_passed = 0;

    button_event_arbiter #(.N(4), .DEBOUNCE_CYCLES(16)) dut (
        .sysclk    (sysclk),
        .rst       (rst),
        .btn       (btn),
        .evt_ready (evt_ready),
        .evt_valid (evt_valid),
        .evt_id    (evt_id),
        .dropped   (dropped),
        .pending   (pending)
    );

    initial sysclk = 1'b0;
    always #5 sysclk = ~sysclk;

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge sysclk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_valid"}, 32'(evt_valid), 32'd0);
        check({tag, "_dropped"}, 32'(dropped), 32'd0);
    endtask

    task automatic check_evt(input string tag, input logic [1:0] id);
        check({tag, "_valid"}, 32'(evt_valid), 32'd1);
        check({tag, "_id"}, 32'(evt_id), 32'(id));
    endtask

    initial begin
        rst       = 1'b1;
        btn       = 4'b0000;
        evt_ready = 1'b0;
        tick(2);
        check("rst_valid", 32'(evt_valid), 32'd0);
        check("rst_id", 32'(evt_id), 32'd0);
        check("rst_dropped", 32'(dropped), 32'd0);
        check("rst_pending", 32'(pending), 32'd0);
        rst = 1'b0;

        // Single press of btn[2]: pending after 19 edges, event after 20.
        btn = 4'b0100;
        tick(18);
        check("t1_pending_early", 32'(pending), 32'd0);
        tick(1);
        check("t1_pending", 32'(pending), 32'h4);
        check("t1_valid_early", 32'(evt_valid), 32'd0);
        tick(1);
        check_evt("t1_evt", 2'd2);
        check("t1_pending_clr", 32'(pending), 32'd0);
        for (int i = 0; i < 10; i++) begin
            tick(1);
            check_evt("t1_hold", 2'd2);
        end
        evt_ready = 1'b1;
        tick(1);
        evt_ready = 1'b0;
        check("t1_accept", 32'(evt_valid), 32'd0);
        for (int i = 0; i < 30; i++) begin
            tick(1);
            check_idle("t1_held");
        end
        btn = 4'b0000;
        tick(20);
        check_idle("t1_release");

        // 15-cycle glitches on btn[1] must never debounce.
        for (int r = 0; r < 3; r++) begin
            btn = 4'b0010;
            for (int i = 0; i < 15; i++) begin
                tick(1);
                check_idle("t2_hi");
            end
            btn = 4'b0000;
            for (int i = 0; i < 15; i++) begin
                tick(1);
                check_idle("t2_lo");
            end
        end
        tick(5);
        check("t2_pending", 32'(pending), 32'd0);

        // All four together from pointer 0.
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        evt_ready = 1'b1;
        btn = 4'b1111;
        tick(19);
        check("t3_pending", 32'(pending), 32'hF);
        check("t3_valid_early", 32'(evt_valid), 32'd0);
        tick(1); check_evt("t3_a0", 2'd0);
        check("t3_pending_a0", 32'(pending), 32'hE);
        tick(1); check_evt("t3_a1", 2'd1);
        tick(1); check_evt("t3_a2", 2'd2);
        tick(1); check_evt("t3_a3", 2'd3);
        check("t3_pending_a3", 32'(pending), 32'd0);
        tick(1); check("t3_a_end", 32'(evt_valid), 32'd0);
        btn = 4'b0000;
        tick(20);
        check_idle("t3_rel");
        // One grant to channel 1 leaves the pointer at 2.
        btn = 4'b0010;
        tick(20); check_evt("t3_ptr", 2'd1);
        tick(1);  check("t3_ptr_acc", 32'(evt_valid), 32'd0);
        btn = 4'b0000;
        tick(20);
        btn = 4'b1111;
        tick(19); check("t3_pending_b", 32'(pending), 32'hF);
        tick(1); check_evt("t3_b2", 2'd2);
        tick(1); check_evt("t3_b3", 2'd3);
        tick(1); check_evt("t3_b0", 2'd0);
        tick(1); check_evt("t3_b1", 2'd1);
        tick(1); check("t3_b_end", 32'(evt_valid), 32'd0);
        btn = 4'b0000;
        tick(20);
        evt_ready = 1'b0;

        // Pending slot on btn[3], then a dropped third press.
        btn = 4'b1000;
        tick(20); check_evt("t4_first", 2'd3);
        btn = 4'b0000;
        tick(20);
        btn = 4'b1000;
        for (int i = 0; i < 19; i++) begin
            tick(1);
            check("t4_nodrop", 32'(dropped), 32'd0);
        end
        check("t4_pending", 32'(pending), 32'h8);
        check_evt("t4_still", 2'd3);
        btn = 4'b0000;
        tick(20);
        btn = 4'b1000;
        for (int i = 0; i < 18; i++) begin
            tick(1);
            check("t4_predrop", 32'(dropped), 32'd0);
        end
        tick(1);
        check("t4_drop", 32'(dropped), 32'd1);
        check("t4_drop_pending", 32'(pending), 32'h8);
        tick(1);
        check("t4_drop_end", 32'(dropped), 32'd0);
        evt_ready = 1'b1;
        tick(1);
        check_evt("t4_second", 2'd3);
        check("t4_pending_clr", 32'(pending), 32'd0);
        tick(1);
        check("t4_done", 32'(evt_valid), 32'd0);
        evt_ready = 1'b0;
        btn = 4'b0000;
        tick(20);

        // Grant of pending[0] coincides with a fresh rise[0].
        btn = 4'b0001;
        tick(20); check_evt("t5_first", 2'd0);
        btn = 4'b0000;
        tick(20);
        btn = 4'b0001;
        tick(19);
        check("t5_pending", 32'(pending), 32'h1);
        btn = 4'b0000;
        tick(20);
        btn = 4'b0001;
        tick(18);
        evt_ready = 1'b1;
        tick(1);
        check_evt("t5_collide", 2'd0);
        check("t5_keep", 32'(pending), 32'h1);
        check("t5_nodrop", 32'(dropped), 32'd0);
        tick(1);
        check_evt("t5_again", 2'd0);
        check("t5_pending_clr", 32'(pending), 32'd0);
        tick(1);
        check("t5_done", 32'(evt_valid), 32'd0);
        evt_ready = 1'b0;
        btn = 4'b0000;
        tick(20);

        // Reset while an event is presented and pending = 1010.
        btn = 4'b1010;
        tick(19); check("t6_pending_a", 32'(pending), 32'hA);
        tick(1);  check_evt("t6_evt", 2'd1);
        btn = 4'b0000;
        tick(20);
        btn = 4'b1010;
        tick(19);
        check("t6_pending_b", 32'(pending), 32'hA);
        check_evt("t6_evt_b", 2'd1);
        rst = 1'b1;
        btn = 4'b0000;
        tick(1);
        rst = 1'b0;
        check("t6_valid", 32'(evt_valid), 32'd0);
        check("t6_id", 32'(evt_id), 32'd0);
        check("t6_dropped", 32'(dropped), 32'd0);
        check("t6_pending", 32'(pending), 32'd0);
        for (int i = 0; i < 40; i++) begin
            tick(1);
            check_idle("t6_after");
            check("t6_after_pending", 32'(pending), 32'd0);
        end

        $display("%0d/%0d checks passed", n_passed, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/button_event_arbiter.md
Name: button_event_arbiter

Overview:
- Debounces N raw push-button inputs and turns each debounced rising edge into a one-shot event.
- Queues one pending event per button and shares a single event output among the buttons with round-robin arbitration and a valid/ready handshake.
- Sits between board button pins and downstream consumers (counters, mode FSMs), replacing one ad-hoc edge-pulse block per button.

Parameters:
N, 4, number of button channels (1..16).
DEBOUNCE_CYCLES, 16, consecutive sysclk cycles a synchronised input must differ from its stable value before the stable value changes (>= 2).
IDW, derived = clog2(max(N,2)), width of evt_id; not overridable.

Ports:
sysclk  input  1  system clock; all logic on posedge.
rst  input  1  synchronous active-high reset.
btn  input  N  raw asynchronous button levels, active-high.
evt_ready  input  1  consumer accepts evt_id on this cycle when evt_valid=1.
evt_valid  output  1  an event is presented on evt_id.
evt_id  output  IDW  index of the button that generated the presented event.
dropped  output  1  one-cycle pulse: an edge was lost because that channel already had an event pending.
pending  output  N  per-channel pending-event flags (status/debug).

Behaviour:
- Interface: one clock, sysclk; reset rst is synchronous, active-high. All state is sampled on posedge sysclk while rst=1.
- Reset values:
  - evt_valid=0, evt_id=0, dropped=0, pending=0.
  - Synchroniser flops, stable levels and debounce counters all 0.
  - Round-robin pointer = 0.
- Synchroniser: per channel, 2-flop chain on btn[i]; output s[i].
- Debounce, per channel:
  - If s[i]==stable[i], counter clears to 0.
  - Otherwise counter increments. When it would reach DEBOUNCE_CYCLES, stable[i] <= s[i] and the counter clears.
  - Glitches shorter than DEBOUNCE_CYCLES never change stable.
- Edge detect: rise[i] = stable[i] & ~stable_d[i], where stable_d is stable delayed one cycle. Falling edges produce nothing.
- Pending:
  - rise[i] sets pending[i].
  - A grant to channel i clears pending[i].
  - rise[i] in the same cycle as a grant of i: the set wins, so pending[i] stays 1 and the new event is kept.
  - rise[i] while pending[i]=1 and channel i is not being granted that cycle: the edge is discarded and dropped=1 for exactly that cycle.
  - Several simultaneous drops still produce a single-cycle dropped pulse.
- Output slot: a single register. A load is allowed when evt_valid==0 or evt_ready==1, so back-to-back events are possible at one per cycle.
- Handshake:
  - evt_valid and evt_id hold stable until the cycle evt_ready=1 is sampled with evt_valid=1.
  - evt_ready while evt_valid=0 has no effect.
- Arbiter:
  - On a load opportunity, the first pending channel searched from the pointer upward (with wrap N-1 -> 0) is granted. That grant loads evt_id, sets evt_valid=1 and clears pending for the channel.
  - The pointer then becomes (granted+1) mod N.
  - With no pending channel at a load opportunity, evt_valid <= 0 and the pointer is unchanged.
- Latency, idle block:
  - btn rising and held: stable rises DEBOUNCE_CYCLES+2 cycles after the first sampling edge.
  - rise, pending and evt_valid follow in consecutive cycles: pending at +1, evt_valid at +2 after stable.
- A button held through reset: stable is 0 at reset exit, so the held button produces one event after debounce.
- Reset asserted mid-operation discards the presented event and all pending events, with no dropped pulse.

Test Plan:
- N=4, D=16: btn[2] goes to 1 and is held → pending[2]=1 then evt_valid=1, evt_id=2 at cycle 20. Holding evt_ready=0 keeps them stable for 10 cycles; one evt_ready=1 cycle → evt_valid=0 next cycle. No second event while the button is held.
- btn[1] toggles with pulses of 15 cycles high and 15 low → no event and no dropped.
- All four buttons rise together with evt_ready=1 → evt_id sequence 0,1,2,3 on four consecutive cycles, pointer ends at 0. Repeating with the pointer at 2 → sequence 2,3,0,1.
- evt_ready=0, btn[3] pressed, released after debounce and pressed again → first event presented, pending[3]=1 from the second press, no dropped. A third press → dropped pulses exactly 1 cycle; after two accepts, exactly two events with id 3 have been seen.
- Pending[0] granted in the same cycle as a new rise[0] → pending[0] stays 1 and a second id-0 event follows.
- Assert rst for 1 cycle while evt_valid=1 and pending=4'b1010 → all outputs 0 the next cycle; no events afterwards unless a new press occurs.
